// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: h/v counters with combinational sync/active/coordinate
// decodes plus registered line-start, animate and end-of-frame pulses and a frame counter.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 10,
    parameter int unsigned FW       = 16
) (
    input  logic          in_clock,
    input  logic          in_reset,
    input  logic          in_pixel_stb,
    input  logic          in_enable,
    output logic          out_Hsync,
    output logic          out_Vsync,
    output logic          out_blanking,
    output logic          out_active,
    output logic          out_line_start,
    output logic          out_screend,
    output logic          out_animate,
    output logic [CW-1:0] out_x,
    output logic [CW-1:0] out_y,
    output logic [FW-1:0] out_frame
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [CW-1:0] h_q, h_d, v_q, v_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          line_start_q, line_start_d;
    logic          animate_q, animate_d;
    logic          screend_q, screend_d;
    logic          step, h_wrap, h_act, v_act;

    always_comb begin
        step         = in_pixel_stb & in_enable;
        h_wrap       = step && (32'(h_q) == H_TOTAL - 1);
        h_d          = h_q;
        v_d          = v_q;
        frame_d      = frame_q;
        line_start_d = h_wrap;
        animate_d    = h_wrap && (32'(v_q) == V_ACTIVE - 1);
        screend_d    = h_wrap && (32'(v_q) == V_TOTAL - 1);
        if (h_wrap) begin
            h_d = '0;
            v_d = screend_d ? '0 : v_q + CW'(1);
        end else if (step) begin
            h_d = h_q + CW'(1);
        end
        if (screend_d) begin
            frame_d = frame_q + FW'(1);
        end
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            h_q          <= '0;
            v_q          <= '0;
            frame_q      <= '0;
            line_start_q <= 1'b0;
            animate_q    <= 1'b0;
            screend_q    <= 1'b0;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            frame_q      <= frame_d;
            line_start_q <= line_start_d;
            animate_q    <= animate_d;
            screend_q    <= screend_d;
        end
    end

    // Decodes are zero-latency relative to the counters; coordinates clamp during blanking.
    always_comb begin
        h_act          = 32'(h_q) < H_ACTIVE;
        v_act          = 32'(v_q) < V_ACTIVE;
        out_active     = h_act & v_act;
        out_blanking   = ~(h_act & v_act);
        out_x          = h_act ? h_q : CW'(H_ACTIVE - 1);
        out_y          = v_act ? v_q : CW'(V_ACTIVE - 1);
        out_Hsync      = (32'(h_q) >= HS_START && 32'(h_q) < HS_END) ? HS_POL : ~HS_POL;
        out_Vsync      = (32'(v_q) >= VS_START && 32'(v_q) < VS_END) ? VS_POL : ~VS_POL;
        out_line_start = line_start_q;
        out_animate    = animate_q;
        out_screend    = screend_q;
        out_frame      = frame_q;
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: default-size and tiny-size generators driven side by side; expected outputs
// are queued per clock and compared by an independent negedge monitor, plus directed checks.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, fw;
        bit hp, vp;
    } cfg_t;

    typedef struct {
        int h, v, fr;
        bit ls, se, an;
    } mst_t;

    typedef struct packed {
        logic        hs, vs, blank, act, ls, se, an;
        logic [15:0] x, y, frame;
    } obs_t;

    localparam cfg_t CD = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33,
                           fw: 16, hp: 1'b0, vp: 1'b0};
    localparam cfg_t CS = '{ha: 4, hf: 1, hs: 2, hb: 1, va: 3, vf: 1, vs: 1, vb: 1,
                           fw: 2, hp: 1'b1, vp: 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic d_stb = 1'b0, d_en = 1'b0, s_stb = 1'b0, s_en = 1'b0;

    logic        d_hs, d_vs, d_blank, d_act, d_ls, d_se, d_an;
    logic [9:0]  d_x, d_y;
    logic [15:0] d_frame;
    logic        s_hs, s_vs, s_blank, s_act, s_ls, s_se, s_an;
    logic [3:0]  s_x, s_y;
    logic [1:0]  s_frame;

    int n_chk = 0;
    int n_fail = 0;
    mst_t md, ms;
    obs_t q_d[$];
    obs_t q_s[$];

    always #5 clk = ~clk;

    vga_timing_gen u_dflt (
        .in_clock(clk), .in_reset(rst), .in_pixel_stb(d_stb), .in_enable(d_en),
        .out_Hsync(d_hs), .out_Vsync(d_vs), .out_blanking(d_blank), .out_active(d_act),
        .out_line_start(d_ls), .out_screend(d_se), .out_animate(d_an),
        .out_x(d_x), .out_y(d_y), .out_frame(d_frame)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1),
        .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b0), .CW(4), .FW(2)
    ) u_small (
        .in_clock(clk), .in_reset(rst), .in_pixel_stb(s_stb), .in_enable(s_en),
        .out_Hsync(s_hs), .out_Vsync(s_vs), .out_blanking(s_blank), .out_active(s_act),
        .out_line_start(s_ls), .out_screend(s_se), .out_animate(s_an),
        .out_x(s_x), .out_y(s_y), .out_frame(s_frame)
    );

    function automatic mst_t step_model(mst_t m, cfg_t c, bit r, bit step);
        int ht = c.ha + c.hf + c.hs + c.hb;
        int vt = c.va + c.vf + c.vs + c.vb;
        mst_t n = m;
        n.ls = 1'b0;
        n.se = 1'b0;
        n.an = 1'b0;
        if (r) begin
            n.h = 0;
            n.v = 0;
            n.fr = 0;
        end else if (step) begin
            if (m.h == ht - 1) begin
                n.ls = 1'b1;
                n.an = (m.v == c.va - 1);
                n.se = (m.v == vt - 1);
                n.h = 0;
                n.v = (m.v == vt - 1) ? 0 : m.v + 1;
                if (n.se) n.fr = (m.fr + 1) % (1 << c.fw);
            end else begin
                n.h = m.h + 1;
            end
        end
        return n;
    endfunction

    function automatic obs_t decode(mst_t m, cfg_t c);
        obs_t o;
        bit act = (m.h < c.ha) && (m.v < c.va);
        o.hs    = (m.h >= c.ha + c.hf && m.h < c.ha + c.hf + c.hs) ? c.hp : ~c.hp;
        o.vs    = (m.v >= c.va + c.vf && m.v < c.va + c.vf + c.vs) ? c.vp : ~c.vp;
        o.act   = act;
        o.blank = ~act;
        o.ls    = m.ls;
        o.se    = m.se;
        o.an    = m.an;
        o.x     = 16'((m.h < c.ha) ? m.h : c.ha - 1);
        o.y     = 16'((m.v < c.va) ? m.v : c.va - 1);
        o.frame = 16'(m.fr);
        return o;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One expected observation per DUT per clock; the monitor drains one per negedge.
    task automatic tick();
        @(posedge clk);
        md = step_model(md, CD, rst, d_stb & d_en);
        ms = step_model(ms, CS, rst, s_stb & s_en);
        #1;
        q_d.push_back(decode(md, CD));
        q_s.push_back(decode(ms, CS));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        md = step_model(md, CD, 1'b1, 1'b0);
        ms = step_model(ms, CS, 1'b1, 1'b0);
        check("rst_x", 32'(d_x), 0);
        check("rst_y", 32'(d_y), 0);
        check("rst_active", 32'(d_act), 1);
        check("rst_blanking", 32'(d_blank), 0);
        check("rst_hsync", 32'(d_hs), 1);
        check("rst_vsync", 32'(d_vs), 1);
        check("rst_frame", 32'(d_frame), 0);
        check("rst_pulses", 32'({d_ls, d_se, d_an}), 0);
        check("rst_small_hsync", 32'(s_hs), 0);
        q_d.push_back(decode(md, CD));
        q_s.push_back(decode(ms, CS));
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        obs_t e, a;
        if (q_d.size() != 0) begin
            e = q_d.pop_front();
            a = {d_hs, d_vs, d_blank, d_act, d_ls, d_se, d_an, 16'(d_x), 16'(d_y), d_frame};
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL sb_dflt at %0t: got %h expected %h", $time, a, e);
            end
        end
        if (q_s.size() != 0) begin
            e = q_s.pop_front();
            a = {s_hs, s_vs, s_blank, s_act, s_ls, s_se, s_an, 16'(s_x), 16'(s_y), 16'(s_frame)};
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL sb_small at %0t: got %h expected %h", $time, a, e);
            end
        end
    end

    initial begin
        int hs_low, act_low, ls_cnt, se_cnt, an_cnt, both_cnt, hs_high, x_max;
        md = '{h: 0, v: 0, fr: 0, ls: 1'b0, se: 1'b0, an: 1'b0};
        ms = md;
        do_reset();

        // One full default line with a strobe every clock.
        d_stb = 1'b1;
        d_en  = 1'b1;
        hs_low = 0;
        act_low = 0;
        ls_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (!d_hs) hs_low++;
            if (!d_act) act_low++;
            if (d_ls) ls_cnt++;
        end
        check("line_hsync_low_cnt", hs_low, 96);
        check("line_active_low_cnt", act_low, 160);
        check("line_start_cnt", ls_cnt, 1);
        check("line_y", 32'(d_y), 1);
        check("line_x", 32'(d_x), 0);

        // Mid-line asynchronous reset with no clock edge.
        repeat (300) tick();
        check("pre_rst_x", 32'(d_x), 300);
        do_reset();

        // Tiny geometry, five frames; default instance frozen with the strobe still toggling.
        d_en  = 1'b0;
        s_stb = 1'b1;
        s_en  = 1'b1;
        se_cnt = 0;
        an_cnt = 0;
        both_cnt = 0;
        hs_high = 0;
        x_max = 0;
        for (int k = 1; k <= 240; k++) begin
            tick();
            if (s_se) se_cnt++;
            if (s_an) an_cnt++;
            if (s_ls && s_se && !s_an) both_cnt++;
            if (s_hs) hs_high++;
            if (32'(s_x) > x_max) x_max = 32'(s_x);
            if (k == 1) check("small_first_step_x", 32'(s_x), 1);
            if (k == 191) check("small_frame_pre_wrap", 32'(s_frame), 3);
            if (k == 192) check("small_frame_wrap", 32'(s_frame), 0);
        end
        check("small_frame_final", 32'(s_frame), 1);
        check("small_screend_cnt", se_cnt, 5);
        check("small_animate_cnt", an_cnt, 5);
        check("small_ls_se_same_clk", both_cnt, 5);
        check("small_hsync_high_cnt", hs_high, 60);
        check("small_x_clamp", x_max, 3);
        check("small_end_y", 32'(s_y), 0);
        check("frozen_dflt_x", 32'(d_x), 0);

        // Strobe every 4th clock with enable dropped for 10 clocks mid-line.
        s_stb = 1'b0;
        for (int i = 0; i < 400; i++) begin
            d_stb = (i % 4 == 0);
            d_en  = !(i >= 200 && i < 210);
            tick();
            if (i == 0) check("stb4_first_x", 32'(d_x), 1);
            if (i == 209) check("stb4_frozen_x", 32'(d_x), 50);
        end
        check("stb4_final_x", 32'(d_x), 97);
        check("stb4_final_y", 32'(d_y), 0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
